// File: rtl/serial_minmax32.sv
// serial_minmax32: digit-serial, MSB-first magnitude comparator and max/min
// selector for two WIDTH-bit operands, DIGIT bits resolved per cycle.
// Operands enter on a valid/ready handshake and results leave on another.
// Optional build macro: SERIAL_MINMAX_SIGNED_EN (two's-complement compare).
module serial_minmax32 #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [WIDTH-1:0] out_min,
  output logic             out_a_gt_b,
  output logic             busy
);

  localparam int N     = WIDTH / DIGIT;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(N - 1);

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [IDX_W-1:0] idx;
  logic             decided;
  logic             gt;

  logic [DIGIT-1:0] dig_a;
  logic [DIGIT-1:0] dig_b;
  logic             decided_nxt;
  logic             gt_nxt;

  // Select digit i (0 = least significant) of an operand.
  function automatic logic [DIGIT-1:0] get_digit(input logic [WIDTH-1:0] v,
                                                 input logic [IDX_W-1:0] i);
    get_digit = v[int'(i)*DIGIT +: DIGIT];
  endfunction

  // Resolve the current digit; the first differing digit decides the result.
  always_comb begin
    dig_a = get_digit(a_reg, idx);
    dig_b = get_digit(b_reg, idx);
`ifdef SERIAL_MINMAX_SIGNED_EN
    // Flipping the sign bit maps two's-complement order onto unsigned order.
    if (idx == IDX_MSB) begin
      dig_a[DIGIT-1] = ~dig_a[DIGIT-1];
      dig_b[DIGIT-1] = ~dig_b[DIGIT-1];
    end
`endif
    decided_nxt = decided | (dig_a != dig_b);
    gt_nxt      = decided ? gt : (dig_a > dig_b);
  end

  // Control FSM with registered handshake flags and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_max    <= '0;
      out_min    <= '0;
      out_a_gt_b <= 1'b0;
      busy       <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      idx        <= '0;
      decided    <= 1'b0;
      gt         <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_reg    <= in_a;
            b_reg    <= in_b;
            decided  <= 1'b0;
            gt       <= 1'b0;
            idx      <= IDX_MSB;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= CMP;
          end else begin
            in_ready <= 1'b1;
          end
        end
        CMP: begin
          decided <= decided_nxt;
          gt      <= gt_nxt;
          if (idx == '0) begin
            out_a_gt_b <= gt_nxt;
            out_max    <= gt_nxt ? a_reg : b_reg;
            out_min    <= gt_nxt ? b_reg : a_reg;
            out_valid  <= 1'b1;
            state      <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_minmax32.sv
// tb_serial_minmax32: scoreboard bench for serial_minmax32. The driver pushes
// the expected result when a pair is accepted; the monitor pops and compares
// on every output handshake. Honours SERIAL_MINMAX_SIGNED_EN like the DUT.
module tb_serial_minmax32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_max;
  logic [31:0] out_min;
  logic        out_a_gt_b;
  logic        busy;

  typedef struct {
    logic [31:0] mx;
    logic [31:0] mn;
    logic        gt;
  } exp_t;

  exp_t q[$];
  int   applied = 0;
  int   miscompares = 0;
  bit   rand_rdy = 1'b0;

  serial_minmax32 #(.WIDTH(32), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_max(out_max), .out_min(out_min), .out_a_gt_b(out_a_gt_b),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    applied++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
`ifdef SERIAL_MINMAX_SIGNED_EN
    e.gt = $signed(a) > $signed(b);
`else
    e.gt = a > b;
`endif
    e.mx = e.gt ? a : b;
    e.mn = e.gt ? b : a;
    return e;
  endfunction

  // Offer a pair; the expected result is queued at the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] mx, input logic [31:0] mn,
                      input logic gt);
    int n = 0;
    exp_t e;
    @(negedge clk);
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      applied++;
      miscompares++;
      $display("FAIL accept_timeout: in_ready still 0, required 1 at %0t", $time);
      in_valid = 1'b0;
      return;
    end
    e.mx = mx;
    e.mn = mn;
    e.gt = gt;
    q.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_rand(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e = model(a, b);
    send(a, b, e.mx, e.mn, e.gt);
  endtask

  // Wait until every queued result has been consumed and the block is idle.
  task automatic wait_idle();
    int n = 0;
    while (!(q.size() == 0 && in_ready) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!(q.size() == 0 && in_ready)) begin
      applied++;
      miscompares++;
      $display("FAIL idle_timeout: %0d results pending, in_ready=%0b, required 0 and 1",
               q.size(), in_ready);
    end
  endtask

  // Monitor: handshake checks, output stability under backpressure.
  initial begin
    exp_t        e;
    bit          held = 1'b0;
    logic [32:0] hmx, hmn;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        if (in_ready && out_valid)
          check("ready_valid_excl", 32'(in_ready & out_valid), 32'd0);
        if (out_valid && !out_ready) begin
          if (held) begin
            check("hold_max", out_max, hmx[31:0]);
            check("hold_min", out_min, hmn[31:0]);
            check("hold_gt", 32'(out_a_gt_b), 32'(hmx[32]));
          end
          held = 1'b1;
          hmx  = {out_a_gt_b, out_max};
          hmn  = {1'b0, out_min};
        end
        if (out_valid && out_ready) begin
          held = 1'b0;
          if (q.size() == 0) begin
            check("unexpected_out_valid", 32'(out_valid), 32'd0);
          end else begin
            e = q.pop_front();
            check("out_max", out_max, e.mx);
            check("out_min", out_min, e.mn);
            check("out_a_gt_b", 32'(out_a_gt_b), 32'(e.gt));
          end
        end
      end
    end
  end

  // Random output backpressure, enabled only for the random phase.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 2) != 0);
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check("rst_flags", {28'd0, in_ready, out_valid, out_a_gt_b, busy}, 32'd0);
    check("rst_max", out_max, 32'd0);
    check("rst_min", out_min, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Basic pair with latency and return-to-idle timing
    out_ready = 1'b1;
    send(32'h5, 32'h3, 32'h5, 32'h3, 1'b1);
    repeat (7) @(posedge clk);
    #1 check("valid_low_at_E7", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1 check("valid_high_at_E8", 32'(out_valid), 32'd1);
    check("busy_at_E8", 32'(busy), 32'd1);
    @(posedge clk);
    #1 check("in_ready_after_hs", 32'(in_ready), 32'd1);
    check("valid_after_hs", 32'(out_valid), 32'd0);
    check("busy_after_hs", 32'(busy), 32'd0);

    // Tie, LSB decision, sign boundary
    send(32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
    wait_idle();
    send(32'h12345670, 32'h12345671, 32'h12345671, 32'h12345670, 1'b0);
    wait_idle();
`ifdef SERIAL_MINMAX_SIGNED_EN
    send(32'h80000000, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000000, 1'b0);
`else
    send(32'h80000000, 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 1'b1);
`endif
    wait_idle();
    send(32'h00000000, 32'hFFFFFFFF,
`ifdef SERIAL_MINMAX_SIGNED_EN
         32'h00000000, 32'hFFFFFFFF, 1'b1);
`else
         32'hFFFFFFFF, 32'h00000000, 1'b0);
`endif
    wait_idle();

    // Backpressure with an ignored pair offered while DONE
    out_ready = 1'b0;
    send(32'hA0000001, 32'hA0000002, 32'hA0000002, 32'hA0000001, 1'b0);
    begin
      int n = 0;
      while (!out_valid && n < 50) begin
        @(posedge clk);
        #1;
        n++;
      end
      check("bp_valid_seen", 32'(out_valid), 32'd1);
    end
    in_a = 32'hFFFF0000;
    in_b = 32'h0000FFFF;
    in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
      check("bp_max_stable", out_max, 32'hA0000002);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    send(32'h0F0F0F0F, 32'h0F0F0F0E, 32'h0F0F0F0F, 32'h0F0F0F0E, 1'b1);
    wait_idle();

    // Reset during the third compare cycle
    send(32'h11111111, 32'h22222222, 32'h22222222, 32'h11111111, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    q.delete();
    #1;
    check("midrst_flags", {28'd0, in_ready, out_valid, out_a_gt_b, busy}, 32'd0);
    check("midrst_max", out_max, 32'd0);
    check("midrst_min", out_min, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("in_ready_after_midrst", 32'(in_ready), 32'd1);
    check("no_stale_valid", 32'(out_valid), 32'd0);
    send(32'd1, 32'd2, 32'd2, 32'd1, 1'b0);
    wait_idle();

    // Random pairs with random input gaps and output stalls
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = (i % 4 == 0) ? (a ^ (32'h1 << $urandom_range(0, 31))) : $urandom;
      if (i % 16 == 0) b = a;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_rand(a, b);
    end
    rand_rdy = 1'b0;
    #1 out_ready = 1'b1;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
